// File: rtl/tt_um_emern_commit_sched_pkg.sv
// Shared command encodings and field widths for the frame-synchronous commit scheduler.
// Payload width is derived from the polygon field layout: colour + 3 x-coords + 3 y-coords.
package tt_um_emern_commit_sched_pkg;

  localparam int WCOLOR    = 6;
  localparam int WPX       = 7;
  localparam int WPY       = 6;
  localparam int N_POLY    = 6;
  localparam int WPAY_DFLT = WCOLOR + 3 * WPX + 3 * WPY;

  localparam logic [2:0] MAX_SLOT = 3'(N_POLY - 1);

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_CLEAR = 2'd1,
    OP_BG    = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic {
    ST_HOLD  = 1'b0,
    ST_DRAIN = 1'b1
  } sched_state_e;

  // Background writes carry no polygon index, so their slot field is ignored.
  function automatic logic cmd_legal(input logic [1:0] op, input logic [2:0] slot);
    logic ok;
    ok = 1'b1;
    if (op == OP_RSVD) ok = 1'b0;
    if ((op == OP_WRITE || op == OP_CLEAR) && slot > MAX_SLOT) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/tt_um_emern_cmd_fifo.sv
// Show-ahead command FIFO: head visible combinationally, push when full and pop when empty are ignored.
// Single-cycle write-to-read latency; simultaneous push/pop keeps the count unchanged.
module tt_um_emern_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 50,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_emern_commit_sched.sv
// Buffers decoded commands and commits them to the register file only in vertical blank (or at once when display is off).
// upd_* is registered, one cycle after the pop; cmd_ready drops when the FIFO is full and late/illegal commands set sticky overflow.
module tt_um_emern_commit_sched
  import tt_um_emern_commit_sched_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int WPAY          = WPAY_DFLT,
  parameter int MAX_PER_BLANK = 4,
  localparam int CW           = $clog2(DEPTH) + 1,
  localparam int BW           = $clog2(MAX_PER_BLANK + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_hblank,
  input  logic            in_vblank,
  input  logic            display_on,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_op,
  input  logic [2:0]      cmd_slot,
  input  logic [WPAY-1:0] cmd_payload,
  output logic            cmd_ready,
  output logic            en_load,
  output logic            upd_valid,
  output logic [1:0]      upd_op,
  output logic [2:0]      upd_slot,
  output logic [WPAY-1:0] upd_payload,
  output logic [CW-1:0]   pending,
  output logic            overflow
);

  localparam int WE = 2 + 3 + WPAY;

  sched_state_e    state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            vb_q;
  logic            overflow_q, overflow_d;
  logic            upd_valid_q, upd_valid_d;
  logic [1:0]      upd_op_q, upd_op_d;
  logic [2:0]      upd_slot_q, upd_slot_d;
  logic [WPAY-1:0] upd_payload_q, upd_payload_d;

  logic            fifo_full, fifo_empty, fifo_pop, push_ok, legal;
  logic            vb_rise, vb_stop, cap_hit;
  logic [WE-1:0]   fifo_head;
  logic [CW-1:0]   fifo_count;

  assign en_load   = in_hblank | in_vblank | ~display_on;
  assign cmd_ready = ~fifo_full;
  assign pending   = fifo_count;
  assign legal     = cmd_legal(cmd_op, cmd_slot);
  assign push_ok   = cmd_valid & ~fifo_full & legal;
  assign vb_rise   = in_vblank & ~vb_q;
  assign vb_stop   = display_on & vb_q & ~in_vblank;
  assign cap_hit   = display_on & (burst_q >= BW'(MAX_PER_BLANK));

  assign overflow_d = overflow_q | (cmd_valid & (fifo_full | ~legal));

  tt_um_emern_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (WE)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_ok),
    .push_dat_i ({cmd_op, cmd_slot, cmd_payload}),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    burst_d       = burst_q;
    fifo_pop      = 1'b0;
    upd_valid_d   = 1'b0;
    upd_op_d      = upd_op_q;
    upd_slot_d    = upd_slot_q;
    upd_payload_d = upd_payload_q;
    case (state_q)
      ST_HOLD: begin
        if (vb_rise || !display_on) begin
          state_d = ST_DRAIN;
          burst_d = '0;
        end
      end
      ST_DRAIN: begin
        // A vblank fall or an exhausted budget blocks this cycle's pop, not just the next one.
        if (!fifo_empty && !cap_hit && !vb_stop) begin
          fifo_pop    = 1'b1;
          upd_valid_d = 1'b1;
          {upd_op_d, upd_slot_d, upd_payload_d} = fifo_head;
          if (burst_q < BW'(MAX_PER_BLANK)) burst_d = burst_q + 1'b1;
        end
        // With the display off the FSM parks in DRAIN so every push commits next cycle.
        if (display_on &&
            (vb_stop || burst_d >= BW'(MAX_PER_BLANK) ||
             (!push_ok && (fifo_empty || (fifo_pop && fifo_count == CW'(1))))))
          state_d = ST_HOLD;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HOLD;
      burst_q       <= '0;
      vb_q          <= 1'b0;
      overflow_q    <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_op_q      <= '0;
      upd_slot_q    <= '0;
      upd_payload_q <= '0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      vb_q          <= in_vblank;
      overflow_q    <= overflow_d;
      upd_valid_q   <= upd_valid_d;
      upd_op_q      <= upd_op_d;
      upd_slot_q    <= upd_slot_d;
      upd_payload_q <= upd_payload_d;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_op      = upd_op_q;
  assign upd_slot    = upd_slot_q;
  assign upd_payload = upd_payload_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_tt_um_emern_commit_sched.sv
// Directed bench for the commit scheduler: one instance with the default budget, one with a budget of 2 per blank.
// Inputs change 1 ns after each rising edge; registered outputs are sampled there too.
module tb_tt_um_emern_commit_sched;

  localparam int WPAY = 45;

  logic            clk, rst_n;
  logic            in_hblank, in_vblank, display_on;
  logic            cmd_valid;
  logic [1:0]      cmd_op;
  logic [2:0]      cmd_slot;
  logic [WPAY-1:0] cmd_payload;

  logic            a_ready, a_en_load, a_valid, a_overflow;
  logic [1:0]      a_op;
  logic [2:0]      a_slot, a_pending;
  logic [WPAY-1:0] a_payload;

  logic            b_ready, b_en_load, b_valid, b_overflow;
  logic [1:0]      b_op;
  logic [2:0]      b_slot, b_pending;
  logic [WPAY-1:0] b_payload;

  int checks = 0;
  int errors = 0;

  tt_um_emern_commit_sched u_dut (
    .clk(clk), .rst_n(rst_n), .in_hblank(in_hblank), .in_vblank(in_vblank),
    .display_on(display_on), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_slot(cmd_slot), .cmd_payload(cmd_payload), .cmd_ready(a_ready),
    .en_load(a_en_load), .upd_valid(a_valid), .upd_op(a_op), .upd_slot(a_slot),
    .upd_payload(a_payload), .pending(a_pending), .overflow(a_overflow)
  );

  tt_um_emern_commit_sched #(.MAX_PER_BLANK(2)) u_cap (
    .clk(clk), .rst_n(rst_n), .in_hblank(in_hblank), .in_vblank(in_vblank),
    .display_on(display_on), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_slot(cmd_slot), .cmd_payload(cmd_payload), .cmd_ready(b_ready),
    .en_load(b_en_load), .upd_valid(b_valid), .upd_op(b_op), .upd_slot(b_slot),
    .upd_payload(b_payload), .pending(b_pending), .overflow(b_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [2:0] slot, input logic [WPAY-1:0] pay);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_slot    = slot;
    cmd_payload = pay;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_hblank  = 1'b0;
    in_vblank  = 1'b0;
    display_on = 1'b1;
    cmd_valid  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b1; in_hblank = 1'b0; in_vblank = 1'b0; display_on = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_slot = '0; cmd_payload = '0;
    #3 rst_n = 1'b0;
    tick();
    chk("rst_pending", a_pending, 0);
    chk("rst_overflow", a_overflow, 0);
    chk("rst_upd_valid", a_valid, 0);
    chk("rst_upd_fields", {a_op, a_slot, a_payload}, 0);
    chk("rst_ready", a_ready, 1);
    rst_n = 1'b1;
    tick();

    // 1: load window follows blanking only
    chk("t1_en_load_idle", a_en_load, 0);
    chk("t1_ready", a_ready, 1);
    chk("t1_pending", a_pending, 0);
    in_hblank = 1'b1; #1;
    chk("t1_en_load_hblank", a_en_load, 1);
    in_hblank = 1'b0; #1;
    chk("t1_en_load_after", a_en_load, 0);

    // 2: three writes mid-frame, committed in order at vblank rise
    do_reset();
    push(2'd0, 3'd0, 45'd1);
    push(2'd0, 3'd1, 45'd2);
    push(2'd0, 3'd2, 45'd3);
    chk("t2_pending3", a_pending, 3);
    chk("t2_no_commit", a_valid, 0);
    tick(); tick();
    chk("t2_hold_midframe", a_valid, 0);
    in_vblank = 1'b1;
    tick();
    chk("t2_entry_latency", a_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_commit_valid", a_valid, 1);
      chk("t2_commit_slot", a_slot, 3'(i));
      chk("t2_commit_payload", a_payload, 45'(i + 1));
      chk("t2_pending_dec", a_pending, 3'(2 - i));
    end
    tick();
    chk("t2_valid_low", a_valid, 0);
    push(2'd0, 3'd4, 45'd5);
    tick(); tick();
    chk("t2_back_in_hold", a_valid, 0);
    chk("t2_held_pending", a_pending, 1);

    // 3: overflow on the fifth push, order preserved, reset clears sticky flag
    do_reset();
    for (int i = 0; i < 4; i++) push(2'd0, 3'(i), 45'(16 + i));
    chk("t3_pending_full", a_pending, 4);
    chk("t3_ready_low", a_ready, 0);
    chk("t3_no_overflow_yet", a_overflow, 0);
    push(2'd1, 3'd4, 45'd99);
    chk("t3_overflow", a_overflow, 1);
    chk("t3_pending_kept", a_pending, 4);
    in_vblank = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_drain_valid", a_valid, 1);
      chk("t3_drain_slot", a_slot, 3'(i));
      chk("t3_drain_payload", a_payload, 45'(16 + i));
    end
    tick();
    chk("t3_fifth_dropped", a_valid, 0);
    rst_n = 1'b0; #1;
    chk("t3_overflow_reset", a_overflow, 0);

    // 4: budget of two commits per vblank, vblank fall aborts a burst
    do_reset();
    for (int i = 0; i < 4; i++) push(2'd0, 3'(i), 45'(10 + i));
    in_vblank = 1'b1;
    tick();
    chk("t4_entry", b_valid, 0);
    tick();
    chk("t4_c0_valid", b_valid, 1);
    chk("t4_c0_slot", b_slot, 0);
    tick();
    chk("t4_c1_slot", b_slot, 1);
    chk("t4_c1_valid", b_valid, 1);
    tick();
    chk("t4_capped", b_valid, 0);
    chk("t4_left", b_pending, 2);
    tick();
    chk("t4_still_capped", b_valid, 0);
    in_vblank = 1'b0;
    tick(); tick();
    in_vblank = 1'b1;
    tick();
    tick();
    chk("t4_c2_valid", b_valid, 1);
    chk("t4_c2_payload", b_payload, 45'd12);
    tick();
    chk("t4_c3_slot", b_slot, 3);
    chk("t4_empty", b_pending, 0);
    tick();
    chk("t4_done", b_valid, 0);
    in_vblank = 1'b0;
    tick();
    push(2'd0, 3'd4, 45'd20);
    push(2'd1, 3'd5, 45'd21);
    in_vblank = 1'b1;
    tick();
    tick();
    chk("t4_fall_first", b_valid, 1);
    chk("t4_fall_first_slot", b_slot, 4);
    in_vblank = 1'b0;
    tick();
    chk("t4_fall_stops", b_valid, 0);
    chk("t4_fall_pending", b_pending, 1);
    tick();
    chk("t4_fall_held", b_valid, 0);

    // 5: display off passes commands through after one cycle
    do_reset();
    display_on = 1'b0; #1;
    chk("t5_en_load_off", a_en_load, 1);
    tick();
    push(2'd0, 3'd3, 45'h1ABCDEF0123);
    chk("t5_queued", a_pending, 1);
    chk("t5_not_yet", a_valid, 0);
    tick();
    chk("t5_valid", a_valid, 1);
    chk("t5_fields", {a_op, a_slot, a_payload}, {2'd0, 3'd3, 45'h1ABCDEF0123});
    chk("t5_en_load_on", a_en_load, 1);
    tick();
    chk("t5_one_cycle", a_valid, 0);
    push(2'd2, 3'd0, 45'h2A);
    tick();
    chk("t5_second_pass", {a_valid, a_op, a_payload}, {1'b1, 2'd2, 45'h2A});
    chk("t5_cap_ignored", {b_valid, b_op}, {1'b1, 2'd2});

    // 6: illegal commands, then reset in the middle of a drain
    do_reset();
    push(2'd3, 3'd0, 45'd7);
    chk("t6_rsvd_overflow", a_overflow, 1);
    chk("t6_rsvd_pending", a_pending, 0);
    do_reset();
    push(2'd2, 3'd7, 45'h15);
    chk("t6_bg_slot_ignored", {a_overflow, a_pending}, {1'b0, 3'd1});
    push(2'd0, 3'd6, 45'd8);
    chk("t6_slot6_overflow", a_overflow, 1);
    chk("t6_slot6_pending", a_pending, 1);
    push(2'd1, 3'd5, 45'd9);
    push(2'd0, 3'd0, 45'd10);
    chk("t6_pending3", a_pending, 3);
    in_vblank = 1'b1;
    tick();
    tick();
    chk("t6_first_commit", {a_valid, a_op, a_slot}, {1'b1, 2'd2, 3'd7});
    rst_n = 1'b0; #1;
    chk("t6_async_valid", a_valid, 0);
    chk("t6_async_pending", a_pending, 0);
    chk("t6_async_fields", {a_op, a_slot, a_payload}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_emern_commit_sched.md
Name: tt_um_emern_commit_sched

Overview:
- Frame-synchronous command scheduler between the SPI command decoder and the polygon/background register file.
- Buffers decoded commands in a 4-entry FIFO and releases them to the register file only during vertical blank, so geometry never changes mid-frame (no tearing).
- Generates the decoder's en_load window from VGA blanking status.
- When the display is off, commands pass through with one cycle of FIFO latency.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..8.
- WPAY, 45, payload width: color 6 + 3×x 7 + 3×y 6.
- MAX_PER_BLANK, 4, maximum commits released per vblank.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_hblank  in  1  level, horizontal blanking active
- in_vblank  in  1  level, vertical blanking active
- display_on  in  1  level, 0 = display disabled
- cmd_valid  in  1  decoded command available, single-cycle pulse
- cmd_op  in  2  0 = write poly, 1 = clear poly, 2 = set bg, 3 = reserved
- cmd_slot  in  3  polygon index 0..5
- cmd_payload  in  WPAY  packed field data; bg uses bits [5:0]
- cmd_ready  out  1  FIFO not full
- en_load  out  1  SPI load window to decoder
- upd_valid  out  1  one-cycle commit strobe to register file
- upd_op  out  2  committed op
- upd_slot  out  3  committed slot
- upd_payload  out  WPAY  committed payload
- pending  out  3  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky; a command arrived while full or was illegal

Behaviour:
- Reset (asynchronous, active-low): FIFO empty, pointers 0, pending=0, overflow=0, upd_valid=0, upd_op/slot/payload=0, state=HOLD, burst count=0.
- en_load (combinational) = in_hblank | in_vblank | ~display_on. It has no dependence on FIFO state; the decoder stalls its SPI shift outside the window.
- cmd_ready = (pending != DEPTH).
- Push: on cmd_valid & cmd_ready & legal command, write the entry at wr_ptr; wr_ptr wraps modulo DEPTH.
- A command is illegal if cmd_op==3, or if cmd_op in {0,1} with cmd_slot>5.
- cmd_valid while full: the command is dropped, overflow is set, and FIFO contents are unchanged.
- An illegal command is dropped and sets overflow.
- overflow clears only on reset.
- FSM states:
  - HOLD: waits for a rising edge of in_vblank (registered previous value 0, current value 1), or for display_on==0. Either condition moves to DRAIN and clears the burst count.
  - DRAIN: each cycle with pending>0, pop the head and drive upd_* with upd_valid=1 for exactly that cycle (registered output, 1-cycle latency from state entry). Increment the burst count.
  - DRAIN → HOLD when any of these hold:
    - pending==0 after the pop;
    - the burst count reaches MAX_PER_BLANK while display_on==1;
    - in_vblank falls while display_on==1.
  - display_on==0: MAX_PER_BLANK does not apply and the FSM stays in DRAIN; any entry pushed is popped on the next cycle.
- Simultaneous push and pop in the same cycle is allowed:
  - pending is unchanged.
  - When full, the push still fails; cmd_ready reflects the pre-pop state.
- Order is strict FIFO. Multiple writes to the same slot within one blank are all committed in order; the last one wins.
- display_on falling mid-frame: enter DRAIN next cycle.
- display_on rising mid-DRAIN: the cap and in_vblank rules apply from the next cycle.
- Reset asserted mid-burst: outputs return to reset values immediately and queued commands are lost.
- pending width is clog2(DEPTH)+1.

Decomposition:
- Shared constants file (alongside the existing constants): OP_WRITE/OP_CLEAR/OP_BG/OP_RSVD encodings, N_POLY, and the WPAY derivation (WCOLOR + 3×WPX + 3×WPY).
- One sub-module: tt_um_emern_cmd_fifo. It is a synchronous DEPTH×(2+3+WPAY) FIFO with push/pop, full/empty and count, reset asynchronously.
- The FSM, vblank edge detector and en_load logic live in the top-level block.

Test Plan:
1. Reset, then display_on=1, in_vblank=0, in_hblank=0: en_load=0, cmd_ready=1, pending=0. Pulse in_hblank → en_load=1 for the same cycles.
2. Push 3 writes (slots 0,1,2) mid-frame: pending=3 and no upd_valid. On the in_vblank rise, upd_valid=1 for 3 consecutive cycles with slots 0,1,2 in order, then pending=0 and state HOLD.
3. Push 5 commands with DEPTH=4: the 5th is dropped, overflow=1, and cmd_ready=0 after the 4th. Reset → overflow=0.
4. Queue 4 commands with MAX_PER_BLANK=2: first vblank commits 2, second vblank commits the remaining 2. Then queue 2 and drop in_vblank after the first commit: only 1 commits.
5. display_on=0: push write slot 3, payload 45'h1ABCDEF0123 → upd_valid 1 cycle later with matching fields, en_load=1 throughout.
6. cmd_op=3, and cmd_op=0 with slot=6: both dropped, overflow=1, pending unchanged. Also assert rst_n low mid-drain → upd_valid=0 asynchronously and pending=0.
